tile_stim_sequencer: RTL and testbench



---
 rtl/tile_stim_pkg.sv | 23 ++
 rtl/stim_lfsr32.sv | 18 +
 rtl/tile_stim_sequencer.sv | 158 +++++++++++++++
 tb/tb_tile_stim_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_stim_pkg.sv
// Shared types and constants for the CGRA tile stimulus sequencer.
package tile_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_CONFIG,
    ST_RUN,
    ST_DONE
  } state_t;

  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
  localparam logic [31:0] GOLDEN_SEED = 32'h9E37_79B9;

  localparam int RD_ADDR_LSB = 32;
  localparam int RD_DATA_LSB = 0;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and advance enable.
module stim_lfsr32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] seed,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] out
);
  import tile_stim_pkg::*;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      out <= 32'd1;
    else if (load)     out <= seed;
    else if (advance)  out <= lfsr_step(out);
  end

endmodule

// File: rtl/tile_stim_sequencer.sv
// Tile bring-up sequencer: hold reset, stream config words, then drive
// windowed enables and LFSR/counter data channels for a fixed run length.
module tile_stim_sequencer #(
  parameter int          NUM_CH     = 4,
  parameter int          DATA_W     = 16,
  parameter int          NUM_EN     = 2,
  parameter int          CNT_W      = 20,
  parameter int          CFG_AW     = 10,
  parameter int          RST_CYCLES = 8,
  parameter logic [31:0] SEED       = 32'hACE1_0001
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [CFG_AW:0]          cfg_num_words,
  input  logic [CNT_W-1:0]         run_len,
  input  logic [NUM_EN*CNT_W-1:0]  en_start,
  input  logic [NUM_EN*CNT_W-1:0]  en_stop,
  input  logic [NUM_CH-1:0]        ch_mode,
  output logic [CFG_AW-1:0]        cfg_mem_addr,
  input  logic [63:0]              cfg_mem_rdata,
  output logic                     tile_reset,
  output logic [31:0]              config_addr,
  output logic [31:0]              config_data,
  output logic                     config_valid,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_EN-1:0]        en_out,
  output logic [CNT_W-1:0]         count,
  output logic                     busy,
  output logic                     done
);
  import tile_stim_pkg::*;

  localparam int              RW       = $clog2(RST_CYCLES + 1);
  localparam int              CW       = CFG_AW + 2;
  localparam logic [RW-1:0]   RST_LAST = RW'(RST_CYCLES - 1);

  state_t            state;
  logic [RW-1:0]     rst_cnt;
  logic [CW-1:0]     cfg_cnt;
  logic [CW-1:0]     cfg_inc;
  logic [CW-1:0]     n_ext;
  logic              run_last;
  logic              run_enter;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_EN-1:0] en_nxt;
  logic [NUM_CH*DATA_W-1:0] data_nxt;
  logic [31:0]       lfsr_q [NUM_CH];

  assign n_ext     = CW'(cfg_num_words);
  assign cfg_inc   = cfg_cnt + CW'(1);
  assign run_last  = (run_len == '0) || (count == run_len - CNT_W'(1));
  assign lfsr_load = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign lfsr_adv  = (state == ST_RUN);
  assign run_enter = ((state == ST_RESET) && (rst_cnt == RST_LAST) && (cfg_num_words == '0)) ||
                     ((state == ST_CONFIG) && (cfg_cnt == n_ext + CW'(1)));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [31:0] RAW_SEED = SEED ^ 32'(GOLDEN_SEED * (g + 1));
    localparam logic [31:0] CH_SEED  = (RAW_SEED == 32'd0) ? 32'd1 : RAW_SEED;
    stim_lfsr32 u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .seed    (CH_SEED),
      .load    (lfsr_load),
      .advance (lfsr_adv),
      .out     (lfsr_q[g])
    );
  end

  // Values the outputs take in the next RUN cycle (count 0 on RUN entry).
  always_comb begin
    cnt_nxt  = (state == ST_RUN) ? count + CNT_W'(1) : '0;
    en_nxt   = '0;
    data_nxt = '0;
    for (int e = 0; e < NUM_EN; e++) begin
      en_nxt[e] = (cnt_nxt >= en_start[e*CNT_W +: CNT_W]) &&
                  (cnt_nxt <  en_stop[e*CNT_W +: CNT_W]);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      data_nxt[c*DATA_W +: DATA_W] = ch_mode[c] ? DATA_W'(cnt_nxt) :
        DATA_W'((state == ST_RUN) ? lfsr_step(lfsr_q[c]) : lfsr_q[c]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      rst_cnt      <= '0;
      cfg_cnt      <= '0;
      cfg_mem_addr <= '0;
      config_addr  <= '0;
      config_data  <= '0;
      config_valid <= 1'b0;
      tile_reset   <= 1'b1;
      count        <= '0;
      en_out       <= '0;
      data_out     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      config_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RESET;
            rst_cnt    <= '0;
            tile_reset <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_RESET: begin
          rst_cnt <= rst_cnt + RW'(1);
          if (rst_cnt == RST_LAST) begin
            tile_reset <= 1'b0;
            if (cfg_num_words == '0) begin
              state <= ST_RUN;
            end else begin
              state        <= ST_CONFIG;
              cfg_cnt      <= '0;
              cfg_mem_addr <= '0;
            end
          end
        end
        ST_CONFIG: begin
          cfg_cnt <= cfg_inc;
          if (cfg_inc < n_ext) cfg_mem_addr <= CFG_AW'(cfg_inc);
          // Read data for the address of cycle k arrives in cycle k+1.
          if ((cfg_cnt != '0) && (cfg_cnt <= n_ext)) begin
            config_valid <= 1'b1;
            config_addr  <= cfg_mem_rdata[RD_ADDR_LSB +: 32];
            config_data  <= cfg_mem_rdata[RD_DATA_LSB +: 32];
          end
          if (cfg_cnt == n_ext + CW'(1)) state <= ST_RUN;
        end
        ST_RUN: begin
          if (run_last) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            en_out <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (run_enter || ((state == ST_RUN) && !run_last)) begin
        count    <= cnt_nxt;
        en_out   <= en_nxt;
        data_out <= data_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tile_stim_sequencer.sv
// Scoreboard bench for tile_stim_sequencer: expectations are queued per
// absolute cycle by the stimulus and checked by an independent monitor.
module tb_tile_stim_sequencer;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int NEN = 2;
  localparam int CW  = 20;
  localparam int AW  = 10;
  localparam int RST = 8;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [AW:0]         cfg_num_words;
  logic [CW-1:0]       run_len;
  logic [NEN*CW-1:0]   en_start;
  logic [NEN*CW-1:0]   en_stop;
  logic [NCH-1:0]      ch_mode;
  logic [AW-1:0]       cfg_mem_addr;
  logic [63:0]         cfg_mem_rdata;
  logic                tile_reset;
  logic [31:0]         config_addr;
  logic [31:0]         config_data;
  logic                config_valid;
  logic [NCH*DW-1:0]   data_out;
  logic [NEN-1:0]      en_out;
  logic [CW-1:0]       count;
  logic                busy;
  logic                done;

  tile_stim_sequencer #(
    .NUM_CH(NCH), .DATA_W(DW), .NUM_EN(NEN), .CNT_W(CW),
    .CFG_AW(AW), .RST_CYCLES(RST), .SEED(32'hACE1_0001)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_num_words(cfg_num_words), .run_len(run_len),
    .en_start(en_start), .en_stop(en_stop), .ch_mode(ch_mode),
    .cfg_mem_addr(cfg_mem_addr), .cfg_mem_rdata(cfg_mem_rdata),
    .tile_reset(tile_reset), .config_addr(config_addr),
    .config_data(config_data), .config_valid(config_valid),
    .data_out(data_out), .en_out(en_out), .count(count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [0:15];
  always @(posedge clk) cfg_mem_rdata <= mem[cfg_mem_addr[3:0]];

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    passed = 0;
  int    cv_seen = 0;
  int    cv_exp = 0;
  string nm [10] = '{"cfg_word", "count", "en_out", "data_ch0", "data_ch1",
                     "done", "busy", "tile_reset", "config_valid", "cfg_mem_addr"};

  function automatic void push(input int c, input int sel, input logic [63:0] v);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.exp = v;
    q.push_back(e);
  endfunction

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      0: return {config_addr, config_data};
      1: return 64'(count);
      2: return 64'(en_out);
      3: return 64'(data_out[15:0]);
      4: return 64'(data_out[31:16]);
      5: return 64'(done);
      6: return 64'(busy);
      7: return 64'(tile_reset);
      8: return 64'(config_valid);
      9: return 64'(cfg_mem_addr);
      default: return '1;
    endcase
  endfunction

  // Bit-level form of x^32+x^22+x^2+x+1, shifting toward bit 0.
  function automatic logic [31:0] lfsr_ref(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    n[31] = s[0];
    n[21] = s[22] ^ s[0];
    n[1]  = s[2] ^ s[0];
    n[0]  = s[1] ^ s[0];
    return n;
  endfunction

  function automatic logic [31:0] seed_of(input int i);
    logic [31:0] m;
    logic [31:0] r;
    m = 32'h9E37_79B9 * 32'(i + 1);
    r = 32'hACE1_0001 ^ m;
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] a;
    if (config_valid) cv_seen++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      a = actual(e.sel);
      checks++;
      if (e.cyc != cyc)
        $display("FAIL %s: entry for cycle %0d reached at cycle %0d", nm[e.sel], e.cyc, cyc);
      else if (a !== e.exp)
        $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm[e.sel], cyc, a, e.exp);
      else
        passed++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) tick();
    checks++;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      q.delete();
    end else begin
      passed++;
    end
  endtask

  task automatic push_idle(input int c);
    push(c, 7, 64'd1); push(c, 6, 64'd0); push(c, 5, 64'd0);
    push(c, 8, 64'd0); push(c, 1, 64'd0); push(c, 2, 64'd0);
    push(c, 3, 64'd0); push(c, 4, 64'd0); push(c, 9, 64'd0);
  endtask

  task automatic push_reset_cfg(input int s, input int n, input int upto);
    int c0;
    for (int k = 1; k <= RST; k++) begin
      push(s + k, 6, 64'd1); push(s + k, 7, 64'd1); push(s + k, 5, 64'd0);
    end
    c0 = s + RST + 1;
    for (int j = 0; j < upto; j++) begin
      push(c0 + j, 7, 64'd0);
      push(c0 + j, 6, 64'd1);
      if (j < n) push(c0 + j, 9, 64'(j));
      push(c0 + j, 8, (j >= 2) ? 64'd1 : 64'd0);
      if (j >= 2) push(c0 + j, 0, mem[j-2]);
    end
  endtask

  task automatic run_seq(input int n, input int rl, input logic [1:0] mode,
                         input int s0, input int e0, input int s1, input int e1);
    int s, r0, len;
    logic [31:0] lf [2];
    logic [15:0] last [2];
    logic [1:0]  en;
    cfg_num_words = 11'(n);
    run_len       = 20'(rl);
    ch_mode       = mode;
    en_start      = {20'(s1), 20'(s0)};
    en_stop       = {20'(e1), 20'(e0)};
    s = cyc;
    start = 1'b1;
    push_reset_cfg(s, n, (n > 0) ? n + 2 : 0);
    r0  = s + RST + 1 + ((n > 0) ? n + 2 : 0);
    len = (rl == 0) ? 1 : rl;
    cv_exp += n;
    for (int i = 0; i < 2; i++) lf[i] = seed_of(i);
    for (int j = 0; j < len; j++) begin
      push(r0 + j, 1, 64'(j));
      en[0] = (j >= s0) && (j < e0);
      en[1] = (j >= s1) && (j < e1);
      push(r0 + j, 2, 64'(en));
      for (int i = 0; i < 2; i++) begin
        last[i] = mode[i] ? 16'(j) : lf[i][15:0];
        push(r0 + j, 3 + i, 64'(last[i]));
        lf[i] = lfsr_ref(lf[i]);
      end
      push(r0 + j, 6, 64'd1); push(r0 + j, 7, 64'd0); push(r0 + j, 8, 64'd0);
    end
    push(r0 + len, 5, 64'd1); push(r0 + len, 6, 64'd0);
    push(r0 + len, 1, 64'(20'(len - 1))); push(r0 + len, 2, 64'd0);
    push(r0 + len, 3, 64'(last[0])); push(r0 + len, 4, 64'(last[1]));
    tick();
    start = 1'b0;
    drain(len + n + RST + 40);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 16; i++) mem[i] = {32'(i + 16), 32'hD000_0000 | 32'(i)};
    mem[0] = {32'd1, 32'h0000_00AA};
    mem[1] = {32'd2, 32'h0000_00BB};
    mem[2] = {32'd3, 32'h0000_00CC};
    reset_n = 1'b0; start = 1'b0; cfg_num_words = '0; run_len = '0;
    en_start = '0; en_stop = '0; ch_mode = '0;

    tick();
    push_idle(cyc);
    tick();
    reset_n = 1'b1;
    push_idle(cyc); push_idle(cyc + 1); push_idle(cyc + 2);
    drain(10);

    run_seq(3, 4, 2'b10, 1, 3, 0, 0);
    run_seq(0, 5, 2'b01, 0, 5, 2, 4);
    run_seq(2, 0, 2'b00, 0, 1, 1, 0);
    run_seq(0, 700, 2'b10, 100, 612, 110, 110);

    // Abort during CONFIG after the first word has been issued.
    cfg_num_words = 11'd3;
    s = cyc;
    start = 1'b1;
    push_reset_cfg(s, 3, 3);
    cv_exp += 1;
    push(s + 12, 8, 64'd0); push(s + 12, 6, 64'd0); push(s + 12, 7, 64'd1);
    push(s + 12, 1, 64'd0); push(s + 12, 9, 64'd0); push(s + 12, 2, 64'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && cyc < s + 12; i++) tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    drain(5);
    tick();
    run_seq(3, 6, 2'b10, 2, 4, 0, 6);

    checks++;
    if (cv_seen != cv_exp)
      $display("FAIL config_valid_total: got %0d cycles, expected %0d", cv_seen, cv_exp);
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
